// File: rtl/dma_tx_sm.sv
// DMA write-side state machine: drains the DMA byte buffer to the destination
// using AHB word writes or APB byte writes, one pop per data phase/access.
module dma_tx_sm #(
  parameter int unsigned BUF_W  = 4,
  parameter int unsigned XFER_W = 16
) (
  input  logic              hclk,
  input  logic              n_hreset,
  input  logic              xfer_start,
  input  logic              target_apb,
  input  logic              rd_wait_write,
  input  logic [BUF_W-1:0]  buf_count,
  input  logic [XFER_W-1:0] xfer_left,
  input  logic              hready,
  input  logic              ahb_grant,
  input  logic              pready,
  input  logic              double_clk,
  input  logic              abort,
  output logic              ahb_req,
  output logic              ahb_wr_addr,
  output logic              psel,
  output logic              penable,
  output logic              buf_pop,
  output logic [2:0]        pop_bytes,
  output logic              write_complete,
  output logic              wr_done,
  output logic [4:0]        dma_write_state
);

  typedef enum logic [4:0] {
    WIdle      = 5'd0,
    WWaitData  = 5'd1,
    WAhbReq    = 5'd2,
    WAhbAddr   = 5'd3,
    WAhbData   = 5'd4,
    WApbSetup  = 5'd5,
    WApbEnable = 5'd6,
    WBlockDone = 5'd7,
    WFinish    = 5'd8
  } state_e;

  state_e           r_state, w_state_d;
  logic             r_phase, w_phase_d;
  logic             r_abort_pend, w_abort_pend_d;
  logic             w_apb_state;
  logic             w_phase_done;
  logic [2:0]       w_ahb_beat;
  logic [2:0]       w_beat;
  logic [BUF_W-1:0] w_rem;

  // AHB beat is the smallest of a word, what the buffer holds and what is left.
  always_comb begin
    w_ahb_beat = 3'd4;
    if (buf_count < BUF_W'(4)) w_ahb_beat = buf_count[2:0];
    if (xfer_left < XFER_W'(w_ahb_beat)) w_ahb_beat = xfer_left[2:0];
  end

  assign w_apb_state  = (r_state == WApbSetup) || (r_state == WApbEnable);
  assign w_beat       = w_apb_state ? 3'd1 : w_ahb_beat;
  assign w_rem        = buf_count - BUF_W'(w_beat);
  assign w_phase_done = ~double_clk | r_phase;

  // Phase toggle saturates after the first hclk of a state; cleared on every entry.
  assign w_phase_d = (w_apb_state && (w_state_d == r_state)) ? (r_phase | double_clk) : 1'b0;

  always_comb begin
    w_state_d      = r_state;
    w_abort_pend_d = r_abort_pend;
    ahb_req        = 1'b0;
    ahb_wr_addr    = 1'b0;
    psel           = 1'b0;
    penable        = 1'b0;
    buf_pop        = 1'b0;
    pop_bytes      = 3'd0;
    write_complete = 1'b0;
    wr_done        = 1'b0;
    case (r_state)
      WIdle: begin
        w_abort_pend_d = 1'b0;
        if (xfer_start) w_state_d = WWaitData;
      end
      WWaitData: begin
        if (abort || (xfer_left == '0)) begin
          w_state_d = WFinish;
        end else if (rd_wait_write && (buf_count != '0)) begin
          w_state_d = target_apb ? WApbSetup : WAhbReq;
        end
      end
      WAhbReq: begin
        ahb_req = 1'b1;
        if (ahb_grant && hready) w_state_d = WAhbAddr;
        else if (abort)          w_state_d = WFinish;
      end
      WAhbAddr: begin
        ahb_req     = 1'b1;
        ahb_wr_addr = 1'b1;
        if (hready) w_state_d = WAhbData;
      end
      WAhbData: begin
        if (hready) begin
          buf_pop   = 1'b1;
          pop_bytes = w_beat;
          if (abort)            w_state_d = WFinish;
          else if (w_rem != '0) w_state_d = WAhbReq;
          else                  w_state_d = WBlockDone;
        end
      end
      WApbSetup: begin
        psel = 1'b1;
        if (abort)             w_state_d = WFinish;
        else if (w_phase_done) w_state_d = WApbEnable;
      end
      WApbEnable: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (abort) w_abort_pend_d = 1'b1;
        // An abort never cuts an APB access short; it takes effect once it completes.
        if (pready && w_phase_done) begin
          buf_pop   = 1'b1;
          pop_bytes = 3'd1;
          if (abort || r_abort_pend) w_state_d = WFinish;
          else if (w_rem != '0)      w_state_d = WApbSetup;
          else                       w_state_d = WBlockDone;
        end
      end
      WBlockDone: begin
        write_complete = 1'b1;
        w_state_d      = (xfer_left == '0) ? WFinish : WWaitData;
      end
      WFinish: begin
        wr_done        = 1'b1;
        w_abort_pend_d = 1'b0;
        w_state_d      = WIdle;
      end
      default: begin
        w_state_d      = WIdle;
        w_abort_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) begin
      r_state      <= WIdle;
      r_phase      <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_phase      <= w_phase_d;
      r_abort_pend <= w_abort_pend_d;
    end
  end

  assign dma_write_state = r_state;

endmodule

// File: tb/tb_dma_tx_sm.sv
// Randomized scoreboard bench for dma_tx_sm: a block-level model predicts the pop
// sizes and completion pulses; a monitor process compares them as the DUT emits them.
module tb_dma_tx_sm;

  localparam int unsigned BUF_W  = 4;
  localparam int unsigned XFER_W = 16;

  localparam logic [1:0] EvPop  = 2'd0;
  localparam logic [1:0] EvWc   = 2'd1;
  localparam logic [1:0] EvDone = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] val;
  } ev_t;

  logic              hclk = 1'b0;
  logic              n_hreset;
  logic              xfer_start, target_apb, rd_wait_write;
  logic [BUF_W-1:0]  buf_count;
  logic [XFER_W-1:0] xfer_left;
  logic              hready, ahb_grant, pready, double_clk, abort;
  logic              ahb_req, ahb_wr_addr, psel, penable, buf_pop;
  logic [2:0]        pop_bytes;
  logic              write_complete, wr_done;
  logic [4:0]        dma_write_state;

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  logic chk_apb = 1'b0;

  dma_tx_sm #(.BUF_W(BUF_W), .XFER_W(XFER_W)) u_dut (
    .hclk            (hclk),
    .n_hreset        (n_hreset),
    .xfer_start      (xfer_start),
    .target_apb      (target_apb),
    .rd_wait_write   (rd_wait_write),
    .buf_count       (buf_count),
    .xfer_left       (xfer_left),
    .hready          (hready),
    .ahb_grant       (ahb_grant),
    .pready          (pready),
    .double_clk      (double_clk),
    .abort           (abort),
    .ahb_req         (ahb_req),
    .ahb_wr_addr     (ahb_wr_addr),
    .psel            (psel),
    .penable         (penable),
    .buf_pop         (buf_pop),
    .pop_bytes       (pop_bytes),
    .write_complete  (write_complete),
    .wr_done         (wr_done),
    .dma_write_state (dma_write_state)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_expect(input logic [1:0] kind, input logic [2:0] val);
    ev_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_unexpected: got event %0d/%0d expected none at %0t", kind, val, $time);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        n_errors++;
        $display("FAIL sb_event: got event %0d/%0d expected %0d/%0d at %0t",
                 kind, val, e.kind, e.val, $time);
      end
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queue.
  initial begin
    int   psel_cnt = 0;
    int   pen_cnt  = 0;
    logic prev_done = 1'b0;
    forever begin
      @(negedge hclk);
      if (!n_hreset) begin
        chk("reset_outputs", int'({ahb_req, ahb_wr_addr, psel, penable, buf_pop, pop_bytes,
                                   write_complete, wr_done, dma_write_state}), 0);
        psel_cnt  = 0;
        pen_cnt   = 0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) chk("idle_after_done", int'(dma_write_state), 0);
        chk("wc_wd_exclusive", int'(write_complete & wr_done), 0);
        chk("pop_bytes_quiet", buf_pop ? 0 : int'(pop_bytes), 0);
        if (psel)    psel_cnt++;
        if (penable) pen_cnt++;
        if (buf_pop) begin
          sb_expect(EvPop, pop_bytes);
          if (chk_apb) begin
            chk("apb_psel_cycles", psel_cnt, double_clk ? 4 : 2);
            chk("apb_penable_cycles", pen_cnt, double_clk ? 2 : 1);
          end
          psel_cnt = 0;
          pen_cnt  = 0;
        end
        if (write_complete) sb_expect(EvWc, 3'd0);
        if (wr_done) begin
          sb_expect(EvDone, 3'd0);
          psel_cnt = 0;
          pen_cnt  = 0;
        end
        prev_done = wr_done;
      end
    end
  end

  // One clock of the environment: buffer/xfer_left owners react to pops, read side to wc.
  task automatic tick(output logic wd);
    logic       p, wc;
    logic [2:0] pb;
    @(negedge hclk);
    p  = buf_pop;
    pb = pop_bytes;
    wc = write_complete;
    wd = wr_done;
    @(posedge hclk);
    #1;
    if (p) begin
      buf_count = buf_count - BUF_W'(pb);
      xfer_left = xfer_left - XFER_W'(pb);
    end
    if (wc) rd_wait_write = 1'b0;
  endtask

  task automatic idle_inputs();
    xfer_start    = 1'b0;
    target_apb    = 1'b0;
    rd_wait_write = 1'b0;
    buf_count     = '0;
    xfer_left     = '0;
    hready        = 1'b1;
    ahb_grant     = 1'b1;
    pready        = 1'b1;
    double_clk    = 1'b0;
    abort         = 1'b0;
  endtask

  task automatic run_xfer(input int total, input bit apb, input bit dbl,
                          input int fixed_blk, input bit rnd_bus);
    int   blks[$];
    int   left, b, r, s, guard;
    logic wd, done;
    left = total;
    while (left > 0) begin
      b = (fixed_blk != 0) ? fixed_blk : int'($urandom_range(1, (left < 8) ? left : 8));
      if (b > left) b = left;
      blks.push_back(b);
      left -= b;
    end
    // Reference: each block drains in word-or-less chunks (AHB) or single bytes (APB).
    foreach (blks[i]) begin
      r = blks[i];
      while (r > 0) begin
        s = apb ? 1 : ((r > 4) ? 4 : r);
        sb_q.push_back({EvPop, 3'(s)});
        r -= s;
      end
      sb_q.push_back({EvWc, 3'd0});
    end
    sb_q.push_back({EvDone, 3'd0});
    chk_apb    = apb && !rnd_bus;
    target_apb = apb;
    double_clk = dbl;
    xfer_left  = XFER_W'(total);
    xfer_start = 1'b1;
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 3000) begin
      if (blks.size() > 0 && buf_count == '0 && !rd_wait_write && $urandom_range(0, 3) == 0) begin
        buf_count     = BUF_W'(blks.pop_front());
        rd_wait_write = 1'b1;
      end
      if (rnd_bus) begin
        hready    = ($urandom_range(0, 2) != 0);
        ahb_grant = ($urandom_range(0, 2) != 0);
        pready    = ($urandom_range(0, 2) != 0);
      end
      tick(wd);
      done = wd;
      guard++;
    end
    chk("xfer_finished", int'(done), 1);
    idle_inputs();
    chk_apb = 1'b0;
    tick(wd);
  endtask

  initial begin
    logic wd, done;
    int   guard;
    idle_inputs();
    n_hreset = 1'b0;
    repeat (3) tick(wd);
    n_hreset = 1'b1;
    tick(wd);

    run_xfer(8, 1'b0, 1'b0, 8, 1'b0);   // two word pops
    run_xfer(3, 1'b0, 1'b0, 3, 1'b0);   // tail pop of 3
    run_xfer(2, 1'b1, 1'b1, 2, 1'b0);   // APB at half rate
    run_xfer(3, 1'b1, 1'b0, 3, 1'b0);   // APB at full rate
    run_xfer(4, 1'b0, 1'b0, 4, 1'b1);   // AHB with wait states
    run_xfer(16, 1'b0, 1'b0, 8, 1'b0);  // multi-block

    // Abort during APB enable while pready is low: access still completes.
    sb_q.push_back({EvPop, 3'd1});
    sb_q.push_back({EvDone, 3'd0});
    target_apb = 1'b1; xfer_left = 16'd2; buf_count = 4'd2; rd_wait_write = 1'b1;
    pready = 1'b0; xfer_start = 1'b1;
    guard = 0;
    while (!(psel && penable) && guard < 50) begin tick(wd); guard++; end
    chk("apb_enable_reached", int'(psel && penable), 1);
    abort = 1'b1;
    tick(wd);
    abort = 1'b0;
    tick(wd);
    chk("apb_enable_held", int'(penable), 1);
    pready = 1'b1;
    tick(wd);
    tick(wd);
    chk("apb_abort_done", int'(wd), 1);
    idle_inputs();
    tick(wd);

    // Abort while waiting for the AHB grant: no pop, straight to finish.
    sb_q.push_back({EvDone, 3'd0});
    ahb_grant = 1'b0; xfer_left = 16'd4; buf_count = 4'd4; rd_wait_write = 1'b1;
    xfer_start = 1'b1;
    guard = 0;
    while (dma_write_state != 5'd2 && guard < 50) begin tick(wd); guard++; end
    chk("ahb_req_reached", int'(ahb_req), 1);
    abort = 1'b1;
    tick(wd);
    abort = 1'b0;
    tick(wd);
    chk("ahb_abort_done", int'(wd), 1);
    idle_inputs();
    tick(wd);

    // Reset in the AHB address phase clears all outputs without waiting for a clock.
    xfer_left = 16'd16; buf_count = 4'd8; rd_wait_write = 1'b1; xfer_start = 1'b1;
    guard = 0;
    while (dma_write_state != 5'd3 && guard < 50) begin tick(wd); guard++; end
    chk("ahb_addr_reached", int'(ahb_wr_addr), 1);
    n_hreset = 1'b0;
    #1;
    chk("reset_mid_xfer", int'({ahb_req, ahb_wr_addr, psel, penable, buf_pop, pop_bytes,
                                write_complete, wr_done, dma_write_state}), 0);
    idle_inputs();
    tick(wd);
    n_hreset = 1'b1;
    tick(wd);

    for (int i = 0; i < 25; i++) begin
      run_xfer(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 0, 1'b1);
    end

    done = (sb_q.size() == 0);
    chk("sb_drained", int'(done), 1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_tx_sm.md
Name: dma_tx_sm

Overview:
DMA write-side state machine; sits directly downstream of the DMA read state machine and drains the DMA byte buffer to the destination.
- Starts a block once the read side has parked in its wait-for-write state with data in the buffer.
- Performs AHB word writes or APB byte writes, popping the buffer as it goes.
- Returns a one-cycle write_complete pulse, which releases the read side for the next block.

Parameters:
BUF_W, 4, width of the buffer byte count (buffer holds at most 8 bytes)
XFER_W, 16, width of the remaining-transfer byte count

Ports:
hclk  in  1  system clock
n_hreset  in  1  reset; asynchronous, active-low
xfer_start  in  1  channel enabled / transfer started
target_apb  in  1  destination address is in APB space
rd_wait_write  in  1  read state machine is in its wait-for-write state
buf_count  in  BUF_W  bytes currently held in the buffer (0..8)
xfer_left  in  XFER_W  bytes still to be written for the whole transfer
hready  in  1  AHB ready
ahb_grant  in  1  AHB bus grant
pready  in  1  APB ready
double_clk  in  1  APB runs at half hclk rate; each APB phase lasts 2 hclk
abort  in  1  channel abort
ahb_req  out  1  AHB bus request
ahb_wr_addr  out  1  AHB address phase valid (drive htrans NONSEQ, hwrite=1)
psel  out  1  APB select
penable  out  1  APB enable
buf_pop  out  1  one-cycle pop strobe to the buffer
pop_bytes  out  3  bytes consumed by this pop (1..4); 0 when buf_pop=0
write_complete  out  1  one-cycle pulse: block drained
wr_done  out  1  one-cycle pulse: transfer finished or aborted
dma_write_state  out  5  current state, for debug and peer FSMs

Behaviour:
- Reset (asynchronous, n_hreset low) forces state w_idle. All outputs are 0, including the internal phase toggle.
- Reset mid-transfer abandons the bus cycle immediately; no pop is issued.
- State encodings: w_idle=0, w_wait_data=1, w_ahb_req=2, w_ahb_addr=3, w_ahb_data=4, w_apb_setup=5, w_apb_enable=6, w_block_done=7, w_finish=8. Unused codes go to w_idle.
- Beat size:
  - AHB: beat = min(4, buf_count, xfer_left).
  - APB: beat = 1.
  - rem = buf_count - beat, evaluated combinationally from the current inputs.
- Buffer and xfer_left owners update on the edge where buf_pop=1; their new values are visible in the following cycle.
- w_idle: if xfer_start, go to w_wait_data. abort is ignored in this state.
- w_wait_data:
  - if abort or xfer_left==0, go to w_finish;
  - else if rd_wait_write and buf_count!=0, go to w_apb_setup when target_apb=1, otherwise w_ahb_req.
- w_ahb_req: ahb_req=1.
  - if ahb_grant & hready, go to w_ahb_addr (grant wins over a same-cycle abort);
  - else if abort, go to w_finish.
- w_ahb_addr: ahb_req=1, ahb_wr_addr=1. Hold until hready, then go to w_ahb_data.
- w_ahb_data: hold until hready. On that cycle: buf_pop=1, pop_bytes=beat.
  - if abort, go to w_finish;
  - else if rem!=0, go to w_ahb_req;
  - else go to w_block_done.
- w_apb_setup: psel=1, penable=0.
  - if abort, go to w_finish without a pop;
  - else, when the phase is complete, go to w_apb_enable.
  - Phase complete means ~double_clk, or the second hclk of the phase when double_clk=1 (internal toggle, cleared on each state entry).
- w_apb_enable: psel=1, penable=1.
  - When pready & phase complete: buf_pop=1, pop_bytes=1; go to w_apb_setup if rem!=0, else w_block_done.
  - An abort seen during enable is registered; the access completes first, then the FSM goes to w_finish.
- w_block_done: write_complete=1 for exactly one cycle.
  - if xfer_left==0 (already updated by the last pop), go to w_finish;
  - else go to w_wait_data.
- w_finish: wr_done=1 for one cycle, then go to w_idle.
- write_complete and wr_done never assert in the same cycle.
- At most one buf_pop per AHB data phase or per APB access.

Test Plan:
- AHB 8 bytes: target_apb=0, buf_count=8, xfer_left=8, grant and hready always 1 -> two pops of pop_bytes=4, then write_complete in w_block_done, then wr_done in w_finish, then w_idle.
- AHB tail: buf_count=3, xfer_left=3 -> a single pop with pop_bytes=3, then write_complete, then wr_done.
- APB, double_clk=1: buf_count=2, pready=1 -> psel held for 4 hclk per byte with penable high for the last 2, two pops of 1, then write_complete.
- AHB wait states: hready=0 for 3 cycles in w_ahb_data -> no pop until hready=1, and exactly one pop after.
- Abort during w_apb_enable with pready=0 for 2 cycles -> access completes with one pop when pready=1, then w_finish and wr_done, with no write_complete.
- Multi-block: xfer_left=16, buf_count=8 with each block presented via rd_wait_write -> two write_complete pulses, one wr_done; reset asserted mid-w_ahb_addr returns all outputs to 0 immediately.
